// File: rtl/l2_flush_engine.sv
// L2 flush/writeback sequencer: walks every set/way, writes back owned words
// through req_out, then invalidates the line. Way is the inner loop.
module l2_flush_engine #(
  parameter int SETS     = 256,
  parameter int WAYS     = 8,
  parameter int WORDS    = 4,
  parameter int TAG_BITS = 20,
  parameter int CNT_W    = 16,
  localparam int SET_BITS = $clog2(SETS),
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_valid,
  input  logic                         flush_mode,
  output logic                         flush_ready,
  input  logic                         pause,
  output logic                         lmem_rd_en,
  output logic                         lmem_wr_en,
  output logic [SET_BITS-1:0]          lmem_set,
  output logic [WAY_BITS-1:0]          lmem_way,
  input  logic [TAG_BITS-1:0]          lmem_rd_tag,
  input  logic                         lmem_rd_hprot,
  input  logic [WORDS-1:0]             lmem_rd_owned,
  input  logic [WORDS-1:0]             lmem_rd_present,
  output logic                         req_out_valid,
  input  logic                         req_out_ready,
  output logic [TAG_BITS+SET_BITS-1:0] req_out_addr,
  output logic [WORDS-1:0]             req_out_mask,
  output logic                         busy,
  output logic                         flush_done,
  output logic [CNT_W-1:0]             wb_cnt
);

  typedef enum logic [2:0] {IDLE, RD, CHK, WB, INV, ADV, DONE} state_t;

  localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(SETS - 1);
  localparam logic [WAY_BITS-1:0] WAY_LAST = WAY_BITS'(WAYS - 1);

  state_t              state;
  state_t              state_nxt;
  logic                mode_q;
  logic [SET_BITS-1:0] set_q;
  logic [WAY_BITS-1:0] way_q;
  logic                eligible;
  logic                need_wb;
  logic                need_inv;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign eligible   = mode_q | lmem_rd_hprot;
  assign need_wb    = eligible & (|lmem_rd_owned);
  assign need_inv   = eligible & (|lmem_rd_present);
  assign lmem_set   = set_q;
  assign lmem_way   = way_q;
  // Read strobe must drop in the very cycle pause rises, so it is decoded, not registered.
  assign lmem_rd_en = (state == RD) && !pause;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (flush_valid) state_nxt = RD;
      RD:   if (!pause) state_nxt = CHK;
      CHK:  begin
        if (need_wb)       state_nxt = WB;
        else if (need_inv) state_nxt = INV;
        else               state_nxt = ADV;
      end
      WB:   if (req_out_ready) state_nxt = INV;
      INV:  state_nxt = ADV;
      ADV:  state_nxt = (way_q == WAY_LAST && set_q == SET_LAST) ? DONE : RD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      set_q         <= '0;
      way_q         <= '0;
      wb_cnt        <= '0;
      flush_ready   <= 1'b1;
      busy          <= 1'b0;
      flush_done    <= 1'b0;
      lmem_wr_en    <= 1'b0;
      req_out_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      flush_ready   <= (state_nxt == IDLE);
      busy          <= (state_nxt != IDLE);
      flush_done    <= (state_nxt == DONE);
      lmem_wr_en    <= (state_nxt == INV);
      req_out_valid <= (state_nxt == WB);
      if (state == IDLE && flush_valid) begin
        mode_q <= flush_mode;
        set_q  <= '0;
        way_q  <= '0;
        wb_cnt <= '0;
      end
      if (state == WB && req_out_ready) wb_cnt <= sat_inc(wb_cnt);
      if (state == ADV) begin
        if (way_q == WAY_LAST) begin
          way_q <= '0;
          set_q <= set_q + 1'b1;
        end else begin
          way_q <= way_q + 1'b1;
        end
      end
    end
  end

  // Writeback payload is captured at CHK and held untouched through WB.
  always_ff @(posedge clk) begin
    if (state == CHK && need_wb) begin
      req_out_addr <= {lmem_rd_tag, set_q};
      req_out_mask <= lmem_rd_owned;
    end
  end

endmodule

// File: tb/tb_l2_flush_engine.sv
// Bench for l2_flush_engine on a 2-set x 2-way cache: directed table, random
// contents against a line-walk reference model, stall and mid-flush reset sequences.
module tb_l2_flush_engine;

  localparam int SETS = 2, WAYS = 2, WORDS = 4, TAG_BITS = 20, CNT_W = 16;
  localparam int SET_BITS = 1, WAY_BITS = 1, LINES = SETS * WAYS;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         flush_valid, flush_mode, flush_ready, pause;
  logic                         lmem_rd_en, lmem_wr_en;
  logic [SET_BITS-1:0]          lmem_set;
  logic [WAY_BITS-1:0]          lmem_way;
  logic [TAG_BITS-1:0]          lmem_rd_tag;
  logic                         lmem_rd_hprot;
  logic [WORDS-1:0]             lmem_rd_owned, lmem_rd_present;
  logic                         req_out_valid, req_out_ready;
  logic [TAG_BITS+SET_BITS-1:0] req_out_addr;
  logic [WORDS-1:0]             req_out_mask;
  logic                         busy, flush_done;
  logic [CNT_W-1:0]             wb_cnt;

  l2_flush_engine #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS), .TAG_BITS(TAG_BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_valid(flush_valid), .flush_mode(flush_mode),
    .flush_ready(flush_ready), .pause(pause), .lmem_rd_en(lmem_rd_en), .lmem_wr_en(lmem_wr_en),
    .lmem_set(lmem_set), .lmem_way(lmem_way), .lmem_rd_tag(lmem_rd_tag),
    .lmem_rd_hprot(lmem_rd_hprot), .lmem_rd_owned(lmem_rd_owned),
    .lmem_rd_present(lmem_rd_present), .req_out_valid(req_out_valid),
    .req_out_ready(req_out_ready), .req_out_addr(req_out_addr), .req_out_mask(req_out_mask),
    .busy(busy), .flush_done(flush_done), .wb_cnt(wb_cnt));

  always #5 clk = ~clk;

  // Local memory contents (written only by the stimulus process)
  logic [TAG_BITS-1:0] m_tag[LINES];
  logic                m_hprot[LINES];
  logic [WORDS-1:0]    m_owned[LINES];
  logic [WORDS-1:0]    m_present[LINES];

  always @(posedge clk) begin
    if (lmem_rd_en) begin
      lmem_rd_tag     <= m_tag[int'(lmem_set) * WAYS + int'(lmem_way)];
      lmem_rd_hprot   <= m_hprot[int'(lmem_set) * WAYS + int'(lmem_way)];
      lmem_rd_owned   <= m_owned[int'(lmem_set) * WAYS + int'(lmem_way)];
      lmem_rd_present <= m_present[int'(lmem_set) * WAYS + int'(lmem_way)];
    end
  end

  // Monitor: event logs are append-only; tests remember their starting positions
  int          cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, viol = 0;
  logic [24:0] obs_wb[$];
  int          obs_inv[$];
  int          obs_rd[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush_valid && flush_ready) acc_cyc <= cyc;
    if (flush_done) begin
      done_cyc <= cyc;
      done_cnt <= done_cnt + 1;
    end
    if (lmem_rd_en && pause) viol <= viol + 1;
    if (lmem_rd_en) obs_rd.push_back(int'(lmem_set) * WAYS + int'(lmem_way));
    if (req_out_valid && req_out_ready) obs_wb.push_back({req_out_addr, req_out_mask});
    if (lmem_wr_en) obs_inv.push_back(int'(lmem_set) * WAYS + int'(lmem_way));
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: per line, eligible = mode|hprot; owned words are written
  // back then invalidated (5 cycles), present-only lines invalidated (4), else skipped (3).
  logic [24:0] exp_wb[$];
  int          exp_inv[$];
  int          exp_cyc, exp_cnt;

  task automatic model(input logic mode);
    logic [SET_BITS-1:0] sb;
    exp_wb.delete();
    exp_inv.delete();
    exp_cyc = 0;
    exp_cnt = 0;
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        int i;
        i  = s * WAYS + w;
        sb = s[SET_BITS-1:0];
        if ((mode || m_hprot[i]) && m_owned[i] != 0) begin
          exp_wb.push_back({m_tag[i], sb, m_owned[i]});
          exp_inv.push_back(i);
          exp_cnt++;
          exp_cyc += 5;
        end else if ((mode || m_hprot[i]) && m_present[i] != 0) begin
          exp_inv.push_back(i);
          exp_cyc += 4;
        end else begin
          exp_cyc += 3;
        end
      end
    end
  endtask

  task automatic load_clear();
    for (int i = 0; i < LINES; i++) begin
      m_tag[i] = '0; m_hprot[i] = 1'b0; m_owned[i] = '0; m_present[i] = '0;
    end
  endtask

  task automatic start_flush(input logic mode);
    @(negedge clk);
    flush_valid = 1'b1;
    flush_mode  = mode;
    @(negedge clk);
    flush_valid = 1'b0;
  endtask

  task automatic wait_done(input int b_done, input string nm);
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt != b_done) break;
      @(negedge clk);
    end
    if (done_cnt == b_done) chk({nm, ".timeout"}, 64'd0, 64'd1);
  endtask

  int last_lat, wb_base, inv_base;

  // Start a flush already prepared in memory (bench-driven ready/pause) and check
  // everything against the model once it completes.
  task automatic run_check(input logic mode, input string nm, input int extra);
    int b_rd, b_done;
    model(mode);
    wb_base  = obs_wb.size();
    inv_base = obs_inv.size();
    b_rd     = obs_rd.size();
    b_done   = done_cnt;
    start_flush(mode);
    chk({nm, ".busy"}, 64'(busy), 64'd1);
    chk({nm, ".ready_low"}, 64'(flush_ready), 64'd0);
    wait_done(b_done, nm);
    last_lat = done_cyc - acc_cyc - 1;
    chk({nm, ".idle_busy"}, 64'(busy), 64'd0);
    chk({nm, ".idle_ready"}, 64'(flush_ready), 64'd1);
    chk({nm, ".done_pulses"}, 64'(done_cnt - b_done), 64'd1);
    chk({nm, ".latency"}, 64'(last_lat), 64'(exp_cyc + extra));
    chk({nm, ".wb_cnt"}, 64'(wb_cnt), 64'(exp_cnt));
    chk({nm, ".first_rd"}, 64'((obs_rd.size() > b_rd) ? obs_rd[b_rd] : -1), 64'd0);
    chk({nm, ".n_wb"}, 64'(obs_wb.size() - wb_base), 64'(exp_wb.size()));
    for (int i = 0; i < exp_wb.size() && wb_base + i < obs_wb.size(); i++)
      chk($sformatf("%s.wb%0d", nm, i), 64'(obs_wb[wb_base + i]), 64'(exp_wb[i]));
    chk({nm, ".n_inv"}, 64'(obs_inv.size() - inv_base), 64'(exp_inv.size()));
    for (int i = 0; i < exp_inv.size() && inv_base + i < obs_inv.size(); i++)
      chk($sformatf("%s.inv%0d", nm, i), 64'(obs_inv[inv_base + i]), 64'(exp_inv[i]));
  endtask

  typedef struct {
    int                  s, w;
    logic [TAG_BITS-1:0] tag;
    logic                hprot;
    logic [WORDS-1:0]    owned, present;
    logic                mode;
    int                  exp_cnt, exp_inv, exp_lat;
    logic [20:0]         exp_addr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] r1, r2, r3;
    logic [24:0] p;
    int b_wb, b_viol, b_done;

    tbl[0] = '{0, 0, 20'h00000, 1'b0, 4'b0000, 4'b0000, 1'b0, 0, 0, 12, 21'h000000};
    tbl[1] = '{1, 0, 20'h12345, 1'b1, 4'b0101, 4'b0101, 1'b0, 1, 1, 14, 21'h02468B};
    tbl[2] = '{0, 1, 20'hABCDE, 1'b0, 4'b1111, 4'b1111, 1'b0, 0, 0, 12, 21'h000000};
    tbl[3] = '{0, 1, 20'hABCDE, 1'b0, 4'b1111, 4'b1111, 1'b1, 1, 1, 14, 21'h1579BC};
    tbl[4] = '{1, 1, 20'h00000, 1'b1, 4'b0000, 4'b0011, 1'b0, 0, 1, 13, 21'h000000};
    tbl[5] = '{0, 0, 20'h00000, 1'b0, 4'b0000, 4'b0011, 1'b1, 0, 1, 13, 21'h000000};

    rst = 1'b0; flush_valid = 1'b0; flush_mode = 1'b0; pause = 1'b0; req_out_ready = 1'b1;
    load_clear();
    repeat (2) @(negedge clk);
    chk("reset.flush_ready", 64'(flush_ready), 64'd1);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.flush_done", 64'(flush_done), 64'd0);
    chk("reset.req_out_valid", 64'(req_out_valid), 64'd0);
    chk("reset.lmem_rd_en", 64'(lmem_rd_en), 64'd0);
    chk("reset.lmem_wr_en", 64'(lmem_wr_en), 64'd0);
    chk("reset.set_way", 64'({lmem_set, lmem_way}), 64'd0);
    chk("reset.wb_cnt", 64'(wb_cnt), 64'd0);
    rst = 1'b1;

    // Directed single-line table
    for (int v = 0; v < 6; v++) begin
      int li;
      load_clear();
      li = tbl[v].s * WAYS + tbl[v].w;
      m_tag[li] = tbl[v].tag; m_hprot[li] = tbl[v].hprot;
      m_owned[li] = tbl[v].owned; m_present[li] = tbl[v].present;
      run_check(tbl[v].mode, $sformatf("vec%0d", v), 0);
      chk($sformatf("vec%0d.tbl_cnt", v), 64'(wb_cnt), 64'(tbl[v].exp_cnt));
      chk($sformatf("vec%0d.tbl_lat", v), 64'(last_lat), 64'(tbl[v].exp_lat));
      chk($sformatf("vec%0d.tbl_inv", v), 64'(obs_inv.size() - inv_base), 64'(tbl[v].exp_inv));
      if (tbl[v].exp_cnt == 1 && obs_wb.size() > wb_base) begin
        chk($sformatf("vec%0d.tbl_addr", v), 64'(obs_wb[wb_base][24:4]), 64'(tbl[v].exp_addr));
        chk($sformatf("vec%0d.tbl_mask", v), 64'(obs_wb[wb_base][3:0]), 64'(tbl[v].owned));
      end
      if (tbl[v].exp_inv == 1 && obs_inv.size() > inv_base)
        chk($sformatf("vec%0d.tbl_inv_at", v), 64'(obs_inv[inv_base]), 64'(li));
    end

    // Random contents against the model
    for (int it = 0; it < 20; it++) begin
      for (int l = 0; l < LINES; l++) begin
        r1 = $urandom; r2 = $urandom; r3 = $urandom;
        m_tag[l]     = r1[19:0];
        m_hprot[l]   = r1[20];
        m_present[l] = (r3[1:0] == 2'b00) ? 4'b0000 : r2[3:0];
        m_owned[l]   = r2[3:0] & r2[7:4];
      end
      r1 = $urandom;
      run_check(r1[0], $sformatf("rand%0d", it), 0);
    end

    // Pause for 5 cycles at RD, then ready low for 10 cycles in WB
    load_clear();
    m_tag[0] = 20'h0F00D; m_hprot[0] = 1'b1; m_owned[0] = 4'b1000; m_present[0] = 4'b1100;
    model(1'b0);
    b_wb = obs_wb.size(); b_viol = viol; b_done = done_cnt;
    req_out_ready = 1'b0;
    start_flush(1'b0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("stall.rd_paused%0d", i), 64'(lmem_rd_en), 64'd0);
      @(negedge clk);
    end
    pause = 1'b0;
    for (int i = 0; i < 50 && !req_out_valid; i++) @(negedge clk);
    chk("stall.wb_valid", 64'(req_out_valid), 64'd1);
    p = {req_out_addr, req_out_mask};
    chk("stall.payload", 64'(p), 64'(exp_wb[0]));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall.hold_valid%0d", i), 64'(req_out_valid), 64'd1);
      chk($sformatf("stall.hold_payload%0d", i), 64'({req_out_addr, req_out_mask}), 64'(p));
    end
    req_out_ready = 1'b1;
    wait_done(b_done, "stall");
    chk("stall.latency", 64'(done_cyc - acc_cyc - 1), 64'(exp_cyc + 15));
    chk("stall.wb_cnt", 64'(wb_cnt), 64'd1);
    chk("stall.n_wb", 64'(obs_wb.size() - b_wb), 64'd1);
    chk("stall.rd_during_pause", 64'(viol - b_viol), 64'd0);

    // Reset asserted during the second writeback
    load_clear();
    m_tag[0] = 20'h11111; m_hprot[0] = 1'b1; m_owned[0] = 4'b0001; m_present[0] = 4'b0001;
    m_tag[2] = 20'h22222; m_hprot[2] = 1'b1; m_owned[2] = 4'b0010; m_present[2] = 4'b0010;
    b_wb = obs_wb.size();
    start_flush(1'b0);
    for (int i = 0; i < 50 && obs_wb.size() == b_wb; i++) @(negedge clk);
    chk("rst.first_wb", 64'(obs_wb.size() - b_wb), 64'd1);
    req_out_ready = 1'b0;
    for (int i = 0; i < 50 && !req_out_valid; i++) @(negedge clk);
    chk("rst.second_wb_valid", 64'(req_out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst.req_out_valid", 64'(req_out_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.flush_ready", 64'(flush_ready), 64'd1);
    chk("rst.wb_cnt", 64'(wb_cnt), 64'd0);
    chk("rst.set_way", 64'({lmem_set, lmem_way}), 64'd0);
    req_out_ready = 1'b1;
    b_wb = obs_wb.size();
    inv_base = obs_inv.size();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst.quiet%0d", i), 64'({req_out_valid, lmem_wr_en, lmem_rd_en, flush_done}), 64'd0);
    end
    chk("rst.no_late_wb", 64'(obs_wb.size() - b_wb), 64'd0);
    chk("rst.no_late_inv", 64'(obs_inv.size() - inv_base), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.released_wb_cnt", 64'(wb_cnt), 64'd0);
    run_check(1'b0, "rst.restart", 0);
    chk("rst.restart_cnt", 64'(wb_cnt), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/l2_flush_engine.md
Name: l2_flush_engine

Overview:
- Parametrised flush/writeback sequencer for the Spandex L2.
- Replaces the tied-off flush path (ongoing_flush, flush_set/flush_way counters) with a real engine.
- Walks every set/way of the L2 local memory and issues owned-word writebacks (ReqWB) through the req_out channel. Then invalidates the line.
- Supports data-only or flush-all modes, pauses while MSHRs are busy, and counts writebacks for verification.

Parameters:
SETS, 256, number of L2 sets (power of 2, >=2)
WAYS, 8, associativity (power of 2, >=2)
WORDS, 4, words per line (word-granular Spandex state)
TAG_BITS, 20, tag width
CNT_W, 16, writeback counter width
Derived: SET_BITS=$clog2(SETS), WAY_BITS=$clog2(WAYS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
flush_valid  in  1  flush request
flush_mode  in  1  0 = lines with hprot=1 (data) only, 1 = all lines; sampled on accept
flush_ready  out  1  engine idle, accepts request
pause  in  1  MSHR non-empty or set conflict; blocks new lookups
lmem_rd_en  out  1  local memory read strobe
lmem_wr_en  out  1  state write strobe (invalidate all words)
lmem_set  out  SET_BITS  set index for read/write
lmem_way  out  WAY_BITS  way index for read/write
lmem_rd_tag  in  TAG_BITS  tag, valid 1 cycle after lmem_rd_en
lmem_rd_hprot  in  1  hprot, same timing
lmem_rd_owned  in  WORDS  per-word owned (O) mask, same timing
lmem_rd_present  in  WORDS  per-word not-invalid mask, same timing
req_out_valid  out  1  writeback request valid
req_out_ready  in  1  downstream ready
req_out_addr  out  TAG_BITS+SET_BITS  line address {tag,set}
req_out_mask  out  WORDS  words written back
busy  out  1  flush in progress
flush_done  out  1  one-cycle completion pulse
wb_cnt  out  CNT_W  writebacks issued in current/last flush

Behaviour:
- Reset (rst=0, async): state IDLE, set/way counters 0, wb_cnt 0. All strobes, valids, busy and flush_done are 0. flush_ready is 1.
- FSM states: IDLE, RD, CHK, WB, INV, ADV, DONE.
- IDLE:
  - flush_ready=1.
  - flush_valid&flush_ready → latch mode, clear counters and wb_cnt, go RD.
  - busy=1 from the next cycle until DONE inclusive.
- RD:
  - If pause=1, stay in RD with lmem_rd_en=0.
  - Otherwise pulse lmem_rd_en with the current set/way, go CHK.
- CHK (read data valid this cycle):
  - eligible = mode | hprot.
  - eligible & owned≠0 → capture {tag,set}, owned into output regs, go WB.
  - eligible & owned==0 & present≠0 → INV (silent drop of shared/valid words).
  - Otherwise → ADV.
- WB:
  - req_out_valid=1, payload stable until handshake.
  - On req_out_valid&req_out_ready: wb_cnt += 1 (saturates at 2^CNT_W-1), go INV.
  - pause is ignored in WB.
- INV: lmem_wr_en=1 for one cycle at the same set/way, go ADV.
- ADV:
  - Way is the inner loop, set the outer.
  - If way==WAYS-1: way←0, set++.
  - If set==SETS-1 and way==WAYS-1 → DONE, else → RD.
- DONE: flush_done=1 for one cycle, busy=1, → IDLE. wb_cnt holds until the next accepted flush.
- Per-line cost: 3 cycles when skipped (RD,CHK,ADV), 4 when invalidated, 5+ when written back (plus ready stalls).
- lmem_set/lmem_way are driven from the counters in every state and are held constant from RD through INV.
- flush_valid while busy is ignored (flush_ready=0) and not queued.
- rst asserted mid-flush: immediate abort to the reset values; no partial req_out or write strobe may be emitted after rst falls.

Test Plan:
- SETS=2, WAYS=2, all lines present=0 → no req_out, no lmem_wr_en; flush_done exactly 12 cycles after accept (4 lines×3); wb_cnt=0.
- Line set1/way0: tag=0x12345, hprot=1, owned=4'b0101, mode=0 → one req_out with addr={0x12345,1}, mask=0101, then lmem_wr_en at set1/way0; wb_cnt=1.
- Line hprot=0, owned=4'b1111: mode=0 → skipped, no write; mode=1 → written back, wb_cnt=1.
- present=4'b0011, owned=0 → lmem_wr_en with no req_out; wb_cnt unchanged.
- Hold req_out_ready=0 for 10 cycles and pause=1 for 5 cycles at RD → payload stable, no lmem_rd_en while paused, completion delayed by exactly 15 cycles.
- Assert rst during WB of the second line → outputs reach their reset values asynchronously, flush_ready=1; a new flush restarts at set0/way0 with wb_cnt=0.
